pir_led_fader: RTL and testbench

//  Multi-channel PIR-driven LED dimmer: generalised successor of the single-LED 20%/100% PWM driver.

---
 rtl/pir_led_fader.sv | 163 ++++++++++++++++
 tb/tb_pir_led_fader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pir_led_fader.sv
// pir_led_fader: per-channel PIR-triggered LED dimmer driven from one shared PWM counter.
// Define PIR_DEBOUNCE_EN to add a per-channel input debounce of DEB_CYCLES cycles.
module pir_led_fader #(
  parameter int CHANNELS     = 2,
  parameter int PERIOD       = 100,
  parameter int IDLE_DUTY    = 20,
  parameter int ACTIVE_DUTY  = 100,
  parameter int RAMP_STEP    = 5,
  parameter int HOLD_PERIODS = 50,
  parameter int DEB_CYCLES   = 8
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pir_in,
  output logic [CHANNELS-1:0] led_out,
  output logic [CHANNELS-1:0] active
);
  localparam int CW   = $clog2(PERIOD + 1);
  localparam int HW   = (HOLD_PERIODS > 0) ? $clog2(HOLD_PERIODS + 1) : 1;
  localparam int STEP = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;

  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
  localparam logic [CW-1:0] IDLE_D  = CW'(IDLE_DUTY);
  localparam logic [CW:0]   IDLE_W  = (CW+1)'(IDLE_DUTY);
  localparam logic [CW:0]   ACT_W   = (CW+1)'(ACTIVE_DUTY);
  localparam logic [CW:0]   STEP_W  = (CW+1)'(STEP);
  localparam logic [HW-1:0] HOLD_W  = HW'(HOLD_PERIODS);

  if (PERIOD < 2 || RAMP_STEP < 1 || DEB_CYCLES < 1) begin : g_bad_params
    $error("pir_led_fader: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_ON, S_FALL} state_t;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CW-1:0]       r_cnt;
  logic                w_pend;
  logic [CHANNELS-1:0] w_pir;

  assign w_pend = (r_cnt == CNT_MAX);

  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pir_in;
      r_sync2 <= r_sync1;
      r_cnt   <= w_pend ? '0 : r_cnt + 1'b1;
    end
  end

`ifdef PIR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [CHANNELS-1:0] r_filt;
  logic [DW-1:0]       r_deb [CHANNELS];

  // Filtered level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < CHANNELS; i++) r_deb[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_deb[i] <= '0;
        end else if (r_deb[i] == DEB_LAST) begin
          r_deb[i]  <= '0;
          r_filt[i] <= ~r_filt[i];
        end else begin
          r_deb[i] <= r_deb[i] + 1'b1;
        end
      end
    end
  end

  assign w_pir = r_filt;
`else
  assign w_pir = r_sync2;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        r_st;
    state_t        w_st;
    logic [CW-1:0] r_duty;
    logic [CW-1:0] w_duty;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold;
    logic [CW:0]   w_up;
    logic [CW:0]   w_dn;
    logic          r_led;
    logic          r_act;

    always_comb begin
      w_up = {1'b0, r_duty} + STEP_W;
      if (w_up > ACT_W) w_up = ACT_W;
      if ({1'b0, r_duty} < IDLE_W + STEP_W) w_dn = IDLE_W;
      else w_dn = {1'b0, r_duty} - STEP_W;
    end

    always_comb begin
      w_st   = r_st;
      w_duty = r_duty;
      w_hold = r_hold;
      unique case (r_st)
        S_IDLE: begin
          if (w_pir[g]) w_st = S_RISE;
        end
        S_RISE: begin
          if (w_pend) begin
            w_duty = w_up[CW-1:0];
            if (w_up == ACT_W) begin
              w_st   = S_ON;
              w_hold = HOLD_W;
            end
          end
        end
        S_ON: begin
          if (w_pir[g]) begin
            w_hold = HOLD_W;
          end else if (w_pend) begin
            if (r_hold == '0) w_st = S_FALL;
            else w_hold = r_hold - 1'b1;
          end
        end
        S_FALL: begin
          // Renewed motion beats a coincident period end
          if (w_pir[g]) begin
            w_st = S_RISE;
          end else if (w_pend) begin
            w_duty = w_dn[CW-1:0];
            if (w_dn == IDLE_W) w_st = S_IDLE;
          end
        end
        default: w_st = S_IDLE;
      endcase
    end

    always_ff @(posedge hwclk) begin
      if (rst) begin
        r_st   <= S_IDLE;
        r_duty <= IDLE_D;
        r_hold <= '0;
        r_led  <= 1'b0;
        r_act  <= 1'b0;
      end else begin
        r_st   <= w_st;
        r_duty <= w_duty;
        r_hold <= w_hold;
        r_led  <= (r_cnt < r_duty);
        r_act  <= (w_st != S_IDLE);
      end
    end

    assign led_out[g] = r_led;
    assign active[g]  = r_act;
  end

endmodule

// File: tb/tb_pir_led_fader.sv
// tb_pir_led_fader: period-level vector table plus directed reset/debounce sequences.
// PWM period is 10 cycles; each table row counts LED-high cycles over aligned periods.
module tb_pir_led_fader;
  logic       hwclk = 1'b0;
  logic       rst;
  logic [1:0] pir_in;
  logic [1:0] led_out;
  logic [1:0] active;

  always #5 hwclk = ~hwclk;

  pir_led_fader #(
    .CHANNELS    (2),
    .PERIOD      (10),
    .IDLE_DUTY   (2),
    .ACTIVE_DUTY (8),
    .RAMP_STEP   (2),
    .HOLD_PERIODS(3),
    .DEB_CYCLES  (4)
  ) dut (
    .hwclk  (hwclk),
    .rst    (rst),
    .pir_in (pir_in),
    .led_out(led_out),
    .active (active)
  );

  // One row = reps aligned PWM periods with the same stimulus and expectation.
  // pulse bits are OR-ed into pir for steps pst..pst+plen-1 of each period.
  typedef struct {
    string      name;
    bit         do_rst;
    logic [1:0] pir;
    logic [1:0] pulse;
    int         pst;
    int         plen;
    int         reps;
    int         hi0;
    int         hi1;
    logic [1:0] act;
  } vec_t;

  vec_t tbl[$];
  int   n_run;
  int   n_fail;
  int   hi0;
  int   hi1;

  task automatic add(input string nm, input bit r, input logic [1:0] p,
                     input logic [1:0] pm, input int ps, input int pl,
                     input int rp, input int h0, input int h1,
                     input logic [1:0] a);
    vec_t v;
    v.name  = nm;
    v.do_rst = r;
    v.pir   = p;
    v.pulse = pm;
    v.pst   = ps;
    v.plen  = pl;
    v.reps  = rp;
    v.hi0   = h0;
    v.hi1   = h1;
    v.act   = a;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] p);
    pir_in = p;
    @(posedge hwclk);
    #1;
    hi0 += int'(led_out[0]);
    hi1 += int'(led_out[1]);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    pir_in = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge hwclk);
      #1;
      check("rst_led", int'(led_out), 0);
      check("rst_act", int'(active), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    pir_in = 2'b00;

`ifdef PIR_DEBOUNCE_EN
    add("t6_short", 1, 2'b00, 2'b01, 0, 3, 1, 2, 2, 2'b00);
    add("t6_long",  0, 2'b00, 2'b01, 0, 4, 1, 2, 2, 2'b01);
    add("t6_ramp",  0, 2'b00, 2'b00, 0, 0, 1, 4, 2, 2'b01);
`else
    add("t1_idle", 1, 2'b00, 2'b00, 0, 0, 3, 2, 2, 2'b00);

    add("t2_p0",   1, 2'b00, 2'b01, 2, 1, 1, 2, 2, 2'b01);
    add("t2_p1",   0, 2'b00, 2'b00, 0, 0, 1, 4, 2, 2'b01);
    add("t2_p2",   0, 2'b00, 2'b00, 0, 0, 1, 6, 2, 2'b01);
    add("t2_on",   0, 2'b00, 2'b00, 0, 0, 5, 8, 2, 2'b01);
    add("t2_f6",   0, 2'b00, 2'b00, 0, 0, 1, 6, 2, 2'b01);
    add("t2_f4",   0, 2'b00, 2'b00, 0, 0, 1, 4, 2, 2'b00);
    add("t2_idle", 0, 2'b00, 2'b00, 0, 0, 2, 2, 2, 2'b00);

    add("t3_p0",   1, 2'b00, 2'b01, 2, 1, 1, 2, 2, 2'b01);
    add("t3_p1",   0, 2'b00, 2'b00, 0, 0, 1, 4, 2, 2'b01);
    add("t3_p2",   0, 2'b00, 2'b00, 0, 0, 1, 6, 2, 2'b01);
    add("t3_on",   0, 2'b00, 2'b00, 0, 0, 5, 8, 2, 2'b01);
    add("t3_re",   0, 2'b01, 2'b00, 0, 0, 1, 6, 2, 2'b01);
    add("t3_on2",  0, 2'b00, 2'b00, 0, 0, 5, 8, 2, 2'b01);
    add("t3_f6",   0, 2'b00, 2'b00, 0, 0, 1, 6, 2, 2'b01);
    add("t3_f4",   0, 2'b00, 2'b00, 0, 0, 1, 4, 2, 2'b00);
    add("t3_idle", 0, 2'b00, 2'b00, 0, 0, 1, 2, 2, 2'b00);

    add("t4_p0",   1, 2'b10, 2'b00, 0, 0, 1, 2, 2, 2'b10);
    add("t4_p1",   0, 2'b10, 2'b00, 0, 0, 1, 2, 4, 2'b10);
    add("t4_p2",   0, 2'b10, 2'b00, 0, 0, 1, 2, 6, 2'b10);
    add("t4_on",   0, 2'b10, 2'b00, 0, 0, 47, 2, 8, 2'b10);
`endif

    foreach (tbl[t]) begin
      if (tbl[t].do_rst) do_reset();
      for (int r = 0; r < tbl[t].reps; r++) begin
        hi0 = 0;
        hi1 = 0;
        for (int j = 0; j < 10; j++) begin
          logic [1:0] p;
          p = tbl[t].pir;
          if (j >= tbl[t].pst && j < tbl[t].pst + tbl[t].plen)
            p = p | tbl[t].pulse;
          step(p);
        end
        check({tbl[t].name, "_hi0"}, hi0, tbl[t].hi0);
        check({tbl[t].name, "_hi1"}, hi1, tbl[t].hi1);
        check({tbl[t].name, "_act"}, int'(active), int'(tbl[t].act));
      end
    end

`ifndef PIR_DEBOUNCE_EN
    // Reset pulse while channel 0 is mid-ramp at duty 6
    do_reset();
    for (int j = 0; j < 25; j++) step((j == 2) ? 2'b01 : 2'b00);
    check("t5_pre_led", int'(led_out[0]), 1);
    check("t5_pre_act", int'(active), 1);
    rst = 1'b1;
    @(posedge hwclk);
    #1;
    check("t5_rst_led", int'(led_out), 0);
    check("t5_rst_act", int'(active), 0);
    rst = 1'b0;
    hi0 = 0;
    hi1 = 0;
    for (int j = 0; j < 10; j++) begin
      step(2'b00);
      if (j < 3) check("t5_phase", int'(led_out[0]), (j < 2) ? 1 : 0);
    end
    check("t5_hi0", hi0, 2);
    check("t5_hi1", hi1, 2);
    check("t5_act", int'(active), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
